// File: rtl/cache_fill_fsm.sv
// Miss-handling controller for one cache: fetches a 16-byte block word by word
// from main memory, writes each word into the data array, then writes the tag.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH      = 16,
  parameter int NUM_BLOCKS      = 128,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss_detected,
  input  logic [ADDR_WIDTH-1:0]      miss_address,
  input  logic                       memory_data_valid,
  input  logic [15:0]                memory_data,
  output logic                       fsm_busy,
  output logic                       memory_read_en,
  output logic [ADDR_WIDTH-1:0]      memory_address,
  output logic [NUM_BLOCKS-1:0]      block_enable,
  output logic [WORDS_PER_BLOCK-1:0] word_enable,
  output logic                       write_data_array,
  output logic                       write_tag_array,
  output logic [15:0]                data_out,
  output logic [7:0]                 tag_out
);

  localparam int IDX_W   = $clog2(NUM_BLOCKS);
  localparam int CNT_W   = $clog2(WORDS_PER_BLOCK);
  localparam int OFF_W   = CNT_W + 1;
  localparam int TAG_LSB = OFF_W + IDX_W;

  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_MASK = {{(ADDR_WIDTH-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_TAGWR = 2'd2
  } state_t;

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   base_r;
  logic [CNT_W-1:0]        req_cnt_r;
  logic [CNT_W-1:0]        rcv_cnt_r;
  logic                    req_done_r;

  function automatic logic [NUM_BLOCKS-1:0] block_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_BLOCKS-1:0] v;
    v      = {NUM_BLOCKS{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [WORDS_PER_BLOCK-1:0] word_onehot(input logic [CNT_W-1:0] idx);
    logic [WORDS_PER_BLOCK-1:0] v;
    v      = {WORDS_PER_BLOCK{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // fill sequencing: state, latched block base, request and return counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      base_r     <= {ADDR_WIDTH{1'b0}};
      req_cnt_r  <= {CNT_W{1'b0}};
      rcv_cnt_r  <= {CNT_W{1'b0}};
      req_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (miss_detected) begin
            base_r     <= miss_address & BASE_MASK;
            req_cnt_r  <= {CNT_W{1'b0}};
            rcv_cnt_r  <= {CNT_W{1'b0}};
            req_done_r <= 1'b0;
            state_r    <= ST_FILL;
          end
        end
        ST_FILL: begin
          // requests and returns advance independently; returns may overlap requests
          if (!req_done_r) begin
            req_cnt_r <= req_cnt_r + CNT_ONE;
            if (req_cnt_r == CNT_LAST) begin
              req_done_r <= 1'b1;
            end
          end
          if (memory_data_valid) begin
            rcv_cnt_r <= rcv_cnt_r + CNT_ONE;
            if (rcv_cnt_r == CNT_LAST) begin
              state_r <= ST_TAGWR;
            end
          end
        end
        ST_TAGWR: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // array and memory strobes decoded from the registered fill state
  always_comb begin
    fsm_busy         = 1'b0;
    memory_read_en   = 1'b0;
    memory_address   = {ADDR_WIDTH{1'b0}};
    block_enable     = {NUM_BLOCKS{1'b0}};
    word_enable      = {WORDS_PER_BLOCK{1'b0}};
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    tag_out          = 8'h00;
    data_out         = memory_data;
    case (state_r)
      ST_IDLE: begin
        fsm_busy = 1'b0;
      end
      ST_FILL: begin
        fsm_busy     = 1'b1;
        block_enable = block_onehot(base_r[TAG_LSB-1:OFF_W]);
        if (!req_done_r) begin
          memory_read_en = 1'b1;
          memory_address = base_r + ADDR_WIDTH'({req_cnt_r, 1'b0});
        end else begin
          memory_read_en = 1'b0;
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          word_enable      = word_onehot(rcv_cnt_r);
        end else begin
          write_data_array = 1'b0;
        end
      end
      ST_TAGWR: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        block_enable    = block_onehot(base_r[TAG_LSB-1:OFF_W]);
        tag_out         = {1'b1, 2'b00, base_r[ADDR_WIDTH-1:TAG_LSB]};
      end
      default: begin
        fsm_busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a latency/gap-configurable memory responder plus a
// fill-level reference model checked against every output on every cycle.
module tb_cache_fill_fsm;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_detected;
  logic [15:0]  miss_address;
  logic         memory_data_valid;
  logic [15:0]  memory_data;
  logic         fsm_busy;
  logic         memory_read_en;
  logic [15:0]  memory_address;
  logic [127:0] block_enable;
  logic [7:0]   word_enable;
  logic         write_data_array;
  logic         write_tag_array;
  logic [15:0]  data_out;
  logic [7:0]   tag_out;

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data_valid(memory_data_valid), .memory_data(memory_data),
    .fsm_busy(fsm_busy), .memory_read_en(memory_read_en), .memory_address(memory_address),
    .block_enable(block_enable), .word_enable(word_enable),
    .write_data_array(write_data_array), .write_tag_array(write_tag_array),
    .data_out(data_out), .tag_out(tag_out)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // memory responder: outstanding requests and the cycle each may first return
  logic [15:0] rq_addr[$];
  int          rq_due[$];
  int          lat_m1   = 3;
  int          gap_max  = 0;
  int          gap_left = 0;
  bit          stray    = 1'b0;

  // reference model of one fill, in terms of elapsed cycles and returned words
  bit          m_busy = 1'b0;
  bit          m_tag  = 1'b0;
  logic [15:0] m_base = 16'h0000;
  int          m_ncyc = 0;
  int          m_nval = 0;

  int           busy_run = 0, last_busy_run = 0, tag_writes = 0, wr_count = 0;
  logic [7:0]   last_tag = 8'h00;
  logic [127:0] last_blk = 128'h0;
  logic [15:0]  last_addr = 16'h0000;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    bit exp_rd, exp_wr;
    @(posedge clk);
    if (!rst) begin
      m_busy = 1'b0; m_tag = 1'b0; gap_left = 0;
      rq_addr.delete(); rq_due.delete();
    end else if (m_tag) begin
      m_busy = 1'b0; m_tag = 1'b0;
    end else if (!m_busy) begin
      if (miss_detected) begin
        m_busy = 1'b1; m_base = {miss_address[15:4], 4'h0}; m_ncyc = 0; m_nval = 0;
      end
    end else begin
      m_ncyc++;
      if (memory_data_valid) begin
        m_nval++;
        if (m_nval == 8) m_tag = 1'b1;
      end
    end
    cyc++;
    #1;
    if (m_busy && !m_tag && rq_addr.size() > 0 && rq_due[0] <= cyc && gap_left == 0) begin
      memory_data_valid = 1'b1;
      memory_data       = mem_word(rq_addr.pop_front());
      void'(rq_due.pop_front());
      gap_left = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    end else begin
      if (gap_left > 0) gap_left--;
      memory_data_valid = stray && !m_busy && ($urandom_range(1, 0) == 1);
      memory_data       = 16'($urandom);
    end
    @(negedge clk);
    exp_rd = m_busy && !m_tag && (m_ncyc < 8);
    exp_wr = m_busy && !m_tag && memory_data_valid;
    chk("busy", fsm_busy, m_busy);
    chk("read_en", memory_read_en, exp_rd);
    if (exp_rd) chk("mem_addr", memory_address, m_base + 16'(2 * m_ncyc));
    chk("wr_data", write_data_array, exp_wr);
    chk("word_en", word_enable, exp_wr ? (8'h01 << m_nval) : 8'h00);
    chk("wr_tag", write_tag_array, m_tag);
    chk("tag_out", tag_out, m_tag ? {1'b1, 2'b00, m_base[15:11]} : 8'h00);
    chk("blk_en", block_enable, m_busy ? (128'h1 << m_base[10:4]) : 128'h0);
    chk("data_out", data_out, memory_data);
    if (exp_wr) chk("wr_word", data_out, mem_word(m_base + 16'(2 * m_nval)));
    if (memory_read_en) begin
      rq_addr.push_back(memory_address);
      rq_due.push_back(cyc + lat_m1);
      last_addr = memory_address;
    end
    if (fsm_busy) busy_run++;
    else begin
      if (busy_run > 0) last_busy_run = busy_run;
      busy_run = 0;
    end
    if (write_data_array) wr_count++;
    if (write_tag_array) begin
      tag_writes++; last_tag = tag_out; last_blk = block_enable;
    end
  endtask

  task automatic wait_tag(input int target, input string tag);
    int n = 0;
    while (tag_writes < target && n < 200) begin
      step();
      n++;
    end
    chk(tag, tag_writes, target);
  endtask

  task automatic start_miss(input logic [15:0] a);
    miss_address  = a;
    miss_detected = 1'b1;
    step();
    miss_detected = 1'b0;
  endtask

  initial begin
    int tw0, wc0, n;
    rst = 1'b0; miss_detected = 1'b0; miss_address = 16'h0000;
    memory_data_valid = 1'b0; memory_data = 16'h0000;
    step(); step();
    chk("rst_addr", memory_address, 16'h0000);
    chk("rst_tag", tag_out, 8'h00);
    rst = 1'b1;
    step();

    // miss at 0x1234, memory latency 4
    start_miss(16'h1234);
    wait_tag(1, "t1_done");
    step();
    chk("t1_busy_len", last_busy_run, 12);
    chk("t1_tag", last_tag, 8'h82);
    chk("t1_blk", last_blk, 128'h1 << 35);
    chk("t1_last_addr", last_addr, 16'h123E);
    chk("t1_writes", wr_count, 8);

    // top of address space, no wrap
    start_miss(16'hFFFE);
    wait_tag(2, "t2_done");
    step();
    chk("t2_tag", last_tag, 8'h9F);
    chk("t2_blk", last_blk, 128'h1 << 127);
    chk("t2_last_addr", last_addr, 16'hFFFE);
    chk("t2_busy_len", last_busy_run, 12);

    // reset after three returned words
    wc0 = wr_count; tw0 = tag_writes;
    start_miss(16'h2468);
    n = 0;
    while (wr_count < wc0 + 3 && n < 100) begin step(); n++; end
    chk("t3_three_words", wr_count, wc0 + 3);
    rst = 1'b0;
    step();
    chk("t3_busy0", fsm_busy, 1'b0);
    chk("t3_addr0", memory_address, 16'h0000);
    chk("t3_blk0", block_enable, 128'h0);
    chk("t3_rd0", memory_read_en, 1'b0);
    rst = 1'b1;
    wc0 = wr_count;
    for (int i = 0; i < 6; i++) step();
    chk("t3_no_tag", tag_writes, tw0);
    chk("t3_no_wr", wr_count, wc0);
    start_miss(16'h0040);
    wait_tag(tw0 + 1, "t3_refill");
    chk("t3_tag", last_tag, 8'h80);
    chk("t3_blk", last_blk, 128'h1 << 4);

    // miss held high across two fills, address changed mid-fill
    step();
    tw0 = tag_writes;
    miss_address = 16'h1234; miss_detected = 1'b1;
    for (int i = 0; i < 4; i++) step();
    miss_address = 16'h5678;
    wait_tag(tw0 + 1, "t4_first");
    chk("t4_tag1", last_tag, 8'h82);
    chk("t4_blk1", last_blk, 128'h1 << 35);
    step();
    chk("t4_idle_gap", fsm_busy, 1'b0);
    step();
    chk("t4_busy2", fsm_busy, 1'b1);
    chk("t4_addr2", memory_address, 16'h5670);
    miss_detected = 1'b0;
    wait_tag(tw0 + 2, "t4_second");
    chk("t4_tag2", last_tag, 8'h8A);
    chk("t4_blk2", last_blk, 128'h1 << 7'h67);

    // stray valid pulses while idle
    step();
    tw0 = tag_writes; wc0 = wr_count;
    stray = 1'b1;
    for (int i = 0; i < 20; i++) step();
    stray = 1'b0;
    chk("t5_no_tag", tag_writes, tw0);
    chk("t5_no_wr", wr_count, wc0);

    // irregular memory: random addresses, return gaps of 0-5 cycles
    lat_m1 = 1; gap_max = 5;
    for (int k = 0; k < 4; k++) begin
      tw0 = tag_writes; wc0 = wr_count;
      start_miss(16'($urandom));
      wait_tag(tw0 + 1, "t6_done");
      chk("t6_words", wr_count, wc0 + 8);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
